// File: rtl/data_memory_pkg.sv
// Shared FSM state type and default geometry/timing for the block data memory.
package data_memory_pkg;

  localparam int DATA_W_DEFAULT          = 8;
  localparam int WORDS_PER_BLOCK_DEFAULT = 4;
  localparam int ADDR_W_DEFAULT          = 6;
  localparam int LATENCY_DEFAULT         = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter that times one memory access; loads LATENCY-1 and counts to zero.
module mem_latency_counter #(
  parameter int LATENCY = 5,
  parameter int CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(LATENCY - 1);
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/block_data_memory.sv
// Block-wide data memory with a fixed multi-cycle access time signalled by busywait.
module block_data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEFAULT,
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEFAULT,
  parameter int ADDR_W          = ADDR_W_DEFAULT,
  parameter int LATENCY         = LATENCY_DEFAULT
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              read,
  input  logic                              write,
  input  logic [ADDR_W-1:0]                 address,
  input  logic [DATA_W*WORDS_PER_BLOCK-1:0] writedata,
  output logic [DATA_W*WORDS_PER_BLOCK-1:0] readdata,
  output logic                              busywait,
  output logic                              error
);

  localparam int BLOCK_W = DATA_W * WORDS_PER_BLOCK;
  localparam int DEPTH   = 2 ** ADDR_W;

  state_t              state;
  logic                op_write;
  logic [ADDR_W-1:0]   op_addr;
  logic [BLOCK_W-1:0]  op_data;
  logic [BLOCK_W-1:0]  mem [DEPTH];

  logic request;
  logic accept;
  logic count_zero;
  logic complete;

  assign request  = read ^ write;
  assign accept   = (state == IDLE) && request;
  assign complete = (state == BUSY) && count_zero;
  // Gated by reset so a request held during reset never shows as busy.
  assign busywait = !reset && (accept || (state == BUSY));

  mem_latency_counter #(
    .LATENCY(LATENCY)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .enable(state == BUSY),
    .zero  (count_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state <= BUSY;
        BUSY:    if (count_zero) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The request is captured once; inputs are don't-care until the next IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_write <= 1'b0;
      op_addr  <= '0;
      op_data  <= '0;
    end else if (accept) begin
      op_write <= write;
      op_addr  <= address;
      op_data  <= writedata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else begin
      error <= (state == IDLE) && read && write;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (complete && op_write) begin
      mem[op_addr] <= op_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (complete && !op_write) begin
      readdata <= mem[op_addr];
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: default build plus a LATENCY=1 build.
module tb_block_data_memory;

  logic        clk;
  logic        reset;
  logic        read0, write0, busy0, error0;
  logic [5:0]  address0;
  logic [31:0] writedata0, readdata0;
  logic        read1, write1, busy1, error1;
  logic [5:0]  address1;
  logic [31:0] writedata1, readdata1;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc;

  block_data_memory dut0 (
    .clock(clk), .reset(reset), .read(read0), .write(write0),
    .address(address0), .writedata(writedata0), .readdata(readdata0),
    .busywait(busy0), .error(error0)
  );

  block_data_memory #(.LATENCY(1)) dut1 (
    .clock(clk), .reset(reset), .read(read1), .write(write1),
    .address(address1), .writedata(writedata1), .readdata(readdata1),
    .busywait(busy1), .error(error1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request and holds it until busywait drops (DONE), counting busy cycles.
  task automatic access(input bit sel, input bit is_write, input logic [5:0] a,
                        input logic [31:0] d, output int cycles);
    @(negedge clk);
    if (!sel) begin
      read0 = !is_write; write0 = is_write; address0 = a; writedata0 = d;
    end else begin
      read1 = !is_write; write1 = is_write; address1 = a; writedata1 = d;
    end
    #1;
    cycles = 0;
    while ((sel ? busy1 : busy0) && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
    if (!sel) begin
      read0 = 1'b0; write0 = 1'b0;
    end else begin
      read1 = 1'b0; write1 = 1'b0;
    end
    $display("access sel=%0d %s addr=0x%02h data=0x%08h busy_cycles=%0d rd0=0x%08h rd1=0x%08h",
             sel, is_write ? "WR" : "RD", a, d, cycles, readdata0, readdata1);
  endtask

  initial begin
    reset = 1'b1;
    read0 = 0; write0 = 0; address0 = '0; writedata0 = '0;
    read1 = 0; write1 = 0; address1 = '0; writedata1 = '0;

    @(negedge clk);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_readdata", readdata0, 32'h0);
    check("reset_error", 32'(error0), 32'd0);
    reset = 1'b0;

    access(0, 0, 6'h05, 32'h0, cyc);
    check("rd05_cycles", cyc, 6);
    check("rd05_data", readdata0, 32'h0000_0000);

    access(0, 1, 6'h2A, 32'hDEAD_BEEF, cyc);
    check("wr2a_cycles", cyc, 6);
    check("wr2a_readdata_hold", readdata0, 32'h0000_0000);
    access(0, 0, 6'h2A, 32'h0, cyc);
    check("rd2a_cycles", cyc, 6);
    check("rd2a_data", readdata0, 32'hDEAD_BEEF);

    // Inputs change mid-BUSY; the latched write to 0x03 must win.
    @(negedge clk);
    write0 = 1'b1; address0 = 6'h03; writedata0 = 32'hAAAA_5555;
    @(negedge clk);
    @(negedge clk);
    address0 = 6'h10; writedata0 = 32'h1111_1111;
    cyc = 0;
    while (busy0 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    write0 = 1'b0;
    $display("midbusy write addr=0x03 remaining_busy=%0d", cyc);
    check("midbusy_remaining", cyc, 4);
    check("midbusy_readdata_hold", readdata0, 32'hDEAD_BEEF);
    access(0, 0, 6'h03, 32'h0, cyc);
    check("rd03_data", readdata0, 32'hAAAA_5555);
    access(0, 0, 6'h10, 32'h0, cyc);
    check("rd10_data", readdata0, 32'h0000_0000);

    // read and write together: error pulse only.
    @(negedge clk);
    read0 = 1'b1; write0 = 1'b1; address0 = 6'h2A; writedata0 = 32'h5A5A_5A5A;
    #1;
    check("both_busy_same_cycle", 32'(busy0), 32'd0);
    @(negedge clk);
    check("both_error_pulse", 32'(error0), 32'd1);
    check("both_busy_next", 32'(busy0), 32'd0);
    read0 = 1'b0; write0 = 1'b0;
    @(negedge clk);
    check("both_error_clear", 32'(error0), 32'd0);
    $display("conflict request addr=0x2A error pulsed");
    access(0, 0, 6'h2A, 32'h0, cyc);
    check("both_rd_cycles", cyc, 6);
    check("both_mem_unchanged", readdata0, 32'hDEAD_BEEF);

    // Reset two cycles into a write.
    @(negedge clk);
    write0 = 1'b1; address0 = 6'h07; writedata0 = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy0), 32'd0);
    check("rst_mid_readdata", readdata0, 32'h0);
    write0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("reset asserted mid-write addr=0x07");
    access(0, 0, 6'h07, 32'h0, cyc);
    check("rd07_cycles", cyc, 6);
    check("rd07_data", readdata0, 32'h0000_0000);
    access(0, 0, 6'h2A, 32'h0, cyc);
    check("rd2a_after_reset", readdata0, 32'h0000_0000);

    // LATENCY=1 build, back-to-back.
    access(1, 1, 6'h3F, 32'h1234_5678, cyc);
    check("l1_wr_cycles", cyc, 2);
    check("l1_done_gap", 32'(busy1), 32'd0);
    access(1, 0, 6'h3F, 32'h0, cyc);
    check("l1_rd_cycles", cyc, 2);
    check("l1_rd_data", readdata1, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
